data_mem_responder: RTL

- Memory-side responder for the CPU data port. It accepts one load or store request at a time and answers it after a configurable number of wait states.
- Owns a word-organised data RAM and performs RV32I byte, halfword and word accesses using funct3.
- Stores use byte-lane writes. Loads are sign- or zero-extended.
- Replaces the ideal zero-latency data memory, so the core can later be stalled on a ready/valid handshake.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/data_mem_responder_if.sv | 32 +++
 rtl/load_extend.sv | 32 +++
 rtl/data_mem_responder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the data-memory path.
//   F3_*         : load/store funct3 encodings (size in [1:0], unsigned in [2])
//   rsp_state_e  : responder handshake state
package riscv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } rsp_state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-port bus between the core (master) and the memory responder (slave).
//   req_valid/req_ready : request handshake
//   req_we              : 1 = store, 0 = load
//   req_funct3          : RV32I access size / signedness
//   req_addr            : byte address
//   req_wdata           : right-aligned store data
//   rsp_valid           : one-cycle response pulse
//   rsp_rdata           : extended load data (0 for stores / errors)
//   rsp_err             : access error, qualified by rsp_valid
interface data_mem_responder_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/load_extend.sv
// Load data alignment and extension for RV32I loads.
//   word_i   : 32-bit memory word containing the addressed data
//   lane_i   : byte address bits [1:0]
//   funct3_i : load funct3 (lb/lh/lw/lbu/lhu)
//   data_o   : right-aligned, sign/zero-extended result (0 for other funct3)
module load_extend
   import riscv_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  lane_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[{lane_i, 3'b000} +: 8];
      // Halfwords are aligned, so only lane bit 1 picks the half.
      half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
      case (funct3_i)
         F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
         F3_W:    data_o = word_i;
         F3_BU:   data_o = {24'd0, byte_sel};
         F3_HU:   data_o = {16'd0, half_sel};
         default: data_o = '0;
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data port. Accepts one load/store at a
// time, answers after WAIT_STATES extra cycles, and owns a word-organised RAM
// with byte-lane writes and extended loads.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : request/response handshake (slave side)
module data_mem_responder
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_STATES = 0,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 reset,
   data_mem_responder_if.slave  bus
);

   // Byte-address width of the RAM window.
   localparam int unsigned AW = $clog2(DEPTH_WORDS) + 2;
   localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   rsp_state_e      state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            we_q, we_d;
   logic [2:0]      f3_q, f3_d;
   logic [1:0]      lane_q, lane_d;
   logic [AW-3:0]   idx_q, idx_d;
   logic [31:0]     wdata_q, wdata_d;
   logic            err_q, err_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            rsp_err_q, rsp_err_d;

   logic            fire;
   logic            req_err;
   logic [31:0]     off;
   logic            enter_resp;
   logic [3:0]      be;
   logic [31:0]     wd;
   logic [31:0]     rd_word;
   logic [31:0]     ld_data;

   logic [31:0]     mem [DEPTH_WORDS];

   assign bus.req_ready = (state_q == IDLE) && reset;
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = rsp_err_q;

   assign fire = bus.req_valid && bus.req_ready;

   // Request legality, evaluated on the incoming request.
   always_comb begin
      off     = bus.req_addr - BASE_ADDR;
      req_err = 1'b0;
      if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])          req_err = 1'b1;
      if (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
      // BASE_ADDR is window-aligned, so any bit above the window means out of range.
      if (off[31:AW] != '0)                                          req_err = 1'b1;
      if (!bus.req_we && bus.req_funct3 inside {3'b011, 3'b110, 3'b111}) req_err = 1'b1;
      if (bus.req_we && !(bus.req_funct3 inside {F3_B, F3_H, F3_W}))    req_err = 1'b1;
   end

   // FSM and transaction capture. The RAM access uses the *_d view of the
   // transaction so that the zero-wait path (IDLE -> RESP) sees the request
   // being captured on the same edge.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      f3_d      = f3_q;
      lane_d    = lane_q;
      idx_d     = idx_q;
      wdata_d   = wdata_q;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (fire) begin
               we_d    = bus.req_we;
               f3_d    = bus.req_funct3;
               lane_d  = off[1:0];
               idx_d   = off[AW-1:2];
               wdata_d = bus.req_wdata;
               err_d   = req_err;
               cnt_d   = WAIT_INIT;
               state_d = (WAIT_STATES > 0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign enter_resp = (state_d == RESP) && (state_q != RESP);

   // Store lane enables and replicated write data.
   always_comb begin
      case (f3_d[1:0])
         2'b00: begin
            be = 4'b0001 << lane_d;
            wd = {4{wdata_d[7:0]}};
         end
         2'b01: begin
            be = lane_d[1] ? 4'b1100 : 4'b0011;
            wd = {2{wdata_d[15:0]}};
         end
         default: begin
            be = 4'b1111;
            wd = wdata_d;
         end
      endcase
   end

   assign rd_word = mem[idx_d];

   load_extend u_load_extend (
      .word_i   (rd_word),
      .lane_i   (lane_d),
      .funct3_i (f3_d),
      .data_o   (ld_data)
   );

   // Response data is only live during RESP; it clears on the way back to IDLE.
   always_comb begin
      rdata_d   = '0;
      rsp_err_d = 1'b0;
      if (enter_resp) begin
         rdata_d   = (we_d || err_d) ? 32'd0 : ld_data;
         rsp_err_d = err_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         f3_q      <= '0;
         lane_q    <= '0;
         idx_q     <= '0;
         wdata_q   <= '0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         f3_q      <= f3_d;
         lane_q    <= lane_d;
         idx_q     <= idx_d;
         wdata_q   <= wdata_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   // RAM is not reset. A reset during WAIT drops state to IDLE, so enter_resp
   // never fires for the aborted store.
   always_ff @(posedge clk) begin
      if (enter_resp && we_d && !err_d) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx_d][8*i +: 8] <= wd[8*i +: 8];
         end
      end
   end

endmodule
